// File: rtl/adc_scan_ctrl.sv
// Scanning controller for a 4-channel, 16-clock serial SAR ADC with a one-frame
// address pipeline: each frame sends the next channel address and receives the previous result.
module adc_scan_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [3:0]        ch_mask,
    input  logic              adc_dout,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_din,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        data_ch,
    output logic              data_valid,
    output logic              frame_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    // SHIFT covers halves 0..30; the 32nd (high) half is spent in HOLD.
    localparam logic [4:0]       LAST_HALF = 5'd30;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [4:0]          half_reg;
    logic [3:0]          mask_reg;
    logic [1:0]          addr_reg;
    logic [1:0]          prev_addr_reg;
    logic                priming_reg;
    logic                last_frame_reg;
    logic [15:0]         tx_reg;
    logic [DATA_W-1:0]   rx_reg;

    logic                cs_n_reg;
    logic                sclk_reg;
    logic                din_reg;
    logic [DATA_W-1:0]   data_out_reg;
    logic [1:0]          data_ch_reg;
    logic                data_valid_reg;
    logic                frame_done_reg;
    logic                busy_reg;

    logic [1:0]          prime_ch_next;
    logic [1:0]          adv_ch_next;
    logic [1:0]          low_ch_next;
    logic [3:0][1:0]     next_ch;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Next enabled channel strictly above 'from', wrapping to the lowest one.
    function automatic logic [1:0] next_above(input logic [3:0] m, input int from);
        logic [1:0] r;
        r = lowest_ch(m);
        for (int k = 3; k >= 0; k--) begin
            if (m[k] && (k > from)) r = 2'(k);
        end
        return r;
    endfunction

    function automatic logic [15:0] ctrl_word(input logic [1:0] a);
        return {2'b00, 1'b0, a, 11'b0};
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_next
            assign next_ch[gi] = next_above(mask_reg, gi);
        end
    endgenerate

    assign prime_ch_next = lowest_ch(ch_mask);
    assign low_ch_next   = lowest_ch(mask_reg);
    assign adv_ch_next   = next_ch[addr_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            half_reg       <= '0;
            mask_reg       <= '0;
            addr_reg       <= '0;
            prev_addr_reg  <= '0;
            priming_reg    <= 1'b1;
            last_frame_reg <= 1'b0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            cs_n_reg       <= 1'b1;
            sclk_reg       <= 1'b1;
            din_reg        <= 1'b0;
            data_out_reg   <= '0;
            data_ch_reg    <= '0;
            data_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && (ch_mask != 4'd0)) begin
                        state_reg   <= SETUP;
                        cnt_reg     <= '0;
                        mask_reg    <= ch_mask;
                        addr_reg    <= prime_ch_next;
                        tx_reg      <= ctrl_word(prime_ch_next);
                        priming_reg <= 1'b1;
                        cs_n_reg    <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_reg == HALF_LAST) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= '0;
                        half_reg  <= '0;
                        sclk_reg  <= 1'b0;
                        din_reg   <= tx_reg[15];
                        tx_reg    <= {tx_reg[14:0], 1'b0};
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        if (!half_reg[0]) begin
                            // Rising edge: the ADC data bit is captured on this same cycle.
                            sclk_reg <= 1'b1;
                            rx_reg   <= {rx_reg[DATA_W-2:0], adc_dout};
                        end else begin
                            sclk_reg <= 1'b0;
                            din_reg  <= tx_reg[15];
                            tx_reg   <= {tx_reg[14:0], 1'b0};
                        end
                        if (half_reg == LAST_HALF) begin
                            state_reg <= HOLD;
                        end else begin
                            half_reg <= half_reg + 5'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == HALF_LAST) begin
                        state_reg      <= GAP;
                        cnt_reg        <= '0;
                        cs_n_reg       <= 1'b1;
                        din_reg        <= 1'b0;
                        last_frame_reg <= !priming_reg && (addr_reg == low_ch_next);
                        if (!priming_reg) begin
                            data_valid_reg <= 1'b1;
                            data_out_reg   <= rx_reg;
                            data_ch_reg    <= prev_addr_reg;
                            frame_done_reg <= (addr_reg == low_ch_next);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        if (!last_frame_reg) begin
                            state_reg     <= SETUP;
                            cs_n_reg      <= 1'b0;
                            priming_reg   <= 1'b0;
                            prev_addr_reg <= addr_reg;
                            addr_reg      <= adv_ch_next;
                            tx_reg        <= ctrl_word(adv_ch_next);
                        end else if (continuous && (ch_mask != 4'd0)) begin
                            state_reg   <= SETUP;
                            cs_n_reg    <= 1'b0;
                            priming_reg <= 1'b1;
                            mask_reg    <= ch_mask;
                            addr_reg    <= prime_ch_next;
                            tx_reg      <= ctrl_word(prime_ch_next);
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign adc_cs_n   = cs_n_reg;
    assign adc_sclk   = sclk_reg;
    assign adc_din    = din_reg;
    assign data_out   = data_out_reg;
    assign data_ch    = data_ch_reg;
    assign data_valid = data_valid_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: instance 0 at CLK_DIV=1, instance 1 at CLK_DIV=4, driven by
// an ADC model with a one-frame address pipeline; scans checked against an expected channel list.
module tb_adc_scan_ctrl;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  start;
    logic [1:0]  cont;
    logic [3:0]  mask_a, mask_b;
    logic [1:0]  dout;
    logic [1:0]  cs_n, sclk, din, dvalid, fdone, busy;
    logic [11:0] data_a, data_b;
    logic [1:0]  ch_a, ch_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [11:0] vals [4];

    int          rises [2];
    int          last_rise [2];
    int          busy_cnt [2];
    int          sclk_err [2];
    int          din_err [2];
    logic [15:0] word [2];
    logic [1:0]  ra [2];
    logic [1:0]  prev_cs, prev_sclk, prev_din;

    int          fall_q0[$], fall_q1[$];
    logic [15:0] word_q0[$], word_q1[$];
    logic [13:0] val_q0[$], val_q1[$];
    int          vcyc_q0[$], vcyc_q1[$];
    int          done_q0[$], done_q1[$];

    adc_scan_ctrl #(.CLK_DIV(1), .DATA_W(12)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .continuous(cont[0]), .ch_mask(mask_a),
        .adc_dout(dout[0]), .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .adc_din(din[0]),
        .data_out(data_a), .data_ch(ch_a), .data_valid(dvalid[0]), .frame_done(fdone[0]),
        .busy(busy[0])
    );

    adc_scan_ctrl #(.CLK_DIV(4), .DATA_W(12)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .continuous(cont[1]), .ch_mask(mask_b),
        .adc_dout(dout[1]), .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .adc_din(din[1]),
        .data_out(data_b), .data_ch(ch_b), .data_valid(dvalid[1]), .frame_done(fdone[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and bus monitor, evaluated on the falling clk edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int dv;
            logic [11:0] tv;
            dv = (i == 0) ? 1 : 4;
            if (busy[i] === 1'b1) busy_cnt[i]++;
            if (cs_n[i] === 1'b0 && prev_cs[i] === 1'b1) begin
                rises[i] = 0;
                if (i == 0) fall_q0.push_back(cyc); else fall_q1.push_back(cyc);
            end
            if (cs_n[i] === 1'b0 && sclk[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                if (rises[i] > 0 && (cyc - last_rise[i]) != 2 * dv) sclk_err[i]++;
                if (din[i] !== prev_din[i]) din_err[i]++;
                last_rise[i] = cyc;
                rises[i]++;
                word[i] = {word[i][14:0], din[i]};
            end
            if (cs_n[i] === 1'b1 && din[i] !== 1'b0) din_err[i]++;
            if (cs_n[i] === 1'b1 && prev_cs[i] === 1'b0) begin
                if (i == 0) word_q0.push_back(word[i]); else word_q1.push_back(word[i]);
                ra[i] = word[i][12:11];
            end
            if (dvalid[i] === 1'b1) begin
                if (i == 0) begin val_q0.push_back({ch_a, data_a}); vcyc_q0.push_back(cyc); end
                else begin val_q1.push_back({ch_b, data_b}); vcyc_q1.push_back(cyc); end
            end
            if (fdone[i] === 1'b1) begin
                if (i == 0) done_q0.push_back(cyc); else done_q1.push_back(cyc);
            end
            tv = vals[ra[i]];
            if (cs_n[i] === 1'b0 && rises[i] >= 4 && rises[i] <= 15) dout[i] = tv[15 - rises[i]];
            else dout[i] = 1'b0;
            prev_cs[i]   = cs_n[i];
            prev_sclk[i] = sclk[i];
            prev_din[i]  = din[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear(input int i);
        busy_cnt[i] = 0;
        sclk_err[i] = 0;
        din_err[i]  = 0;
        if (i == 0) begin
            fall_q0.delete(); word_q0.delete(); val_q0.delete(); vcyc_q0.delete(); done_q0.delete();
        end else begin
            fall_q1.delete(); word_q1.delete(); val_q1.delete(); vcyc_q1.delete(); done_q1.delete();
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k;
        k = 0;
        while (busy[i] !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check($sformatf("idle_timeout%0d", i), {31'b0, busy[i]}, 32'd0);
    endtask

    // Expected scan: N+1 frames addressing enabled channels ascending then the lowest again;
    // results for each enabled channel in ascending order.
    task automatic run_scan(input int i, input logic [3:0] m);
        int          en[$];
        int          n, dv, a;
        int          fq[$], vc[$], dq[$];
        logic [15:0] wq[$];
        logic [13:0] vq[$];
        dv = (i == 0) ? 1 : 4;
        clear(i);
        if (i == 0) mask_a = m; else mask_b = m;
        pulse_start(i);
        check($sformatf("busy_up%0d", i), {31'b0, busy[i]}, 32'd1);
        wait_idle(i, 6 * 35 * dv);
        if (i == 0) begin fq = fall_q0; wq = word_q0; vq = val_q0; vc = vcyc_q0; dq = done_q0; end
        else begin fq = fall_q1; wq = word_q1; vq = val_q1; vc = vcyc_q1; dq = done_q1; end
        for (int c = 0; c < 4; c++) if (m[c]) en.push_back(c);
        n = en.size();
        check($sformatf("frames%0d_m%0h", i, m), fq.size(), n + 1);
        for (int f = 0; f < n + 1 && f < wq.size(); f++) begin
            a = (f < n) ? en[f] : en[0];
            check($sformatf("din_word%0d_f%0d", i, f), {16'b0, wq[f]}, {16'b0, 3'b000, 2'(a), 11'b0});
        end
        for (int f = 1; f < fq.size(); f++)
            check($sformatf("frame_period%0d_f%0d", i, f), fq[f] - fq[f-1], 35 * dv);
        check($sformatf("valid_cnt%0d", i), vq.size(), n);
        for (int k = 0; k < n && k < vq.size(); k++)
            check($sformatf("result%0d_k%0d", i, k), {18'b0, vq[k]}, {18'b0, 2'(en[k]), vals[en[k]]});
        check($sformatf("done_cnt%0d", i), dq.size(), 1);
        if (dq.size() > 0 && vc.size() > 0)
            check($sformatf("done_cycle%0d", i), dq[0], vc[vc.size() - 1]);
        check($sformatf("busy_cycles%0d", i), busy_cnt[i], (n + 1) * 35 * dv);
        check($sformatf("sclk_period%0d", i), sclk_err[i], 0);
        check($sformatf("din_stable%0d", i), din_err[i], 0);
    endtask

    initial begin
        int          k, nv;
        logic [3:0]  rm;
        rst = 2'b00; start = 2'b00; cont = 2'b00; mask_a = '0; mask_b = '0;
        prev_cs = 2'b11; prev_sclk = 2'b11; prev_din = 2'b00;
        for (int c = 0; c < 4; c++) begin
            vals[c] = 12'($urandom);
            rises[c % 2] = 0; last_rise[c % 2] = 0; word[c % 2] = '0; ra[c % 2] = '0;
        end
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_cs_n%0d", i), {31'b0, cs_n[i]}, 32'd1);
            check($sformatf("rst_sclk%0d", i), {31'b0, sclk[i]}, 32'd1);
            check($sformatf("rst_din%0d", i), {31'b0, din[i]}, 32'd0);
            check($sformatf("rst_flags%0d", i), {29'b0, dvalid[i], fdone[i], busy[i]}, 32'd0);
        end
        check("rst_data_a", {18'b0, ch_a, data_a}, 32'd0);
        rst = 2'b11;
        tick(2);

        vals[0] = 12'h6B6; vals[1] = 12'h3E6; vals[2] = 12'h2D6; vals[3] = 12'h4B1;
        run_scan(0, 4'b1111);
        run_scan(0, 4'b1010);
        check("hold_data", {18'b0, ch_a, data_a}, {18'b0, 2'd3, vals[3]});
        repeat (4) begin
            for (int c = 0; c < 4; c++) vals[c] = 12'($urandom);
            rm = 4'($urandom_range(1, 15));
            run_scan(0, rm);
        end

        // start with an empty mask does nothing
        clear(0);
        mask_a = 4'b0000;
        pulse_start(0);
        tick(40);
        check("mask0_frames", fall_q0.size(), 0);
        check("mask0_busy", {31'b0, busy[0]}, 32'd0);

        // start while busy is ignored, and a mid-scan mask change has no effect
        clear(0);
        mask_a = 4'b0001;
        pulse_start(0);
        tick(10);
        mask_a = 4'b1111;
        pulse_start(0);
        wait_idle(0, 500);
        check("busy_start_frames", fall_q0.size(), 2);
        check("busy_start_valids", val_q0.size(), 1);

        // continuous mode, mask cleared during the second scan
        clear(0);
        mask_a = 4'b0001;
        cont[0] = 1'b1;
        pulse_start(0);
        k = 0;
        while (fall_q0.size() < 3 && k < 500) begin tick(1); k++; end
        mask_a = 4'b0000;
        wait_idle(0, 500);
        cont[0] = 1'b0;
        check("cont_frames", fall_q0.size(), 4);
        check("cont_dones", done_q0.size(), 2);
        check("cont_valids", val_q0.size(), 2);
        check("cont_busy_cycles", busy_cnt[0], 4 * 35);
        if (val_q0.size() == 2) check("cont_result", {18'b0, val_q0[1]}, {18'b0, 2'd0, vals[0]});

        // continuous dropped mid-scan lets the scan finish
        clear(0);
        mask_a = 4'b0011;
        cont[0] = 1'b1;
        pulse_start(0);
        tick(20);
        cont[0] = 1'b0;
        wait_idle(0, 500);
        check("cont_off_frames", fall_q0.size(), 3);

        // reset near SCLK rising edge 9 of frame 2
        clear(0);
        mask_a = 4'b1111;
        pulse_start(0);
        k = 0;
        while (!(fall_q0.size() == 3 && rises[0] >= 9) && k < 500) begin tick(1); k++; end
        check("rst_reach", fall_q0.size(), 3);
        nv = val_q0.size();
        rst[0] = 1'b0;
        #1;
        check("arst_cs_n", {31'b0, cs_n[0]}, 32'd1);
        check("arst_sclk", {31'b0, sclk[0]}, 32'd1);
        check("arst_busy", {31'b0, busy[0]}, 32'd0);
        check("arst_data", {18'b0, ch_a, data_a}, 32'd0);
        tick(3);
        check("arst_valids_before", nv, 1);
        check("arst_no_partial", val_q0.size(), nv);
        rst[0] = 1'b1;
        tick(2);
        run_scan(0, 4'b1111);

        // slow instance
        for (int c = 0; c < 4; c++) vals[c] = 12'($urandom);
        run_scan(1, 4'b1111);
        rm = 4'($urandom_range(1, 15));
        run_scan(1, rm);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
